// File: rtl/sad_pkg.sv
// Shared types for the SAD template-matching sequencer: FSM state encoding
// and the result codes handed to the UART sender.
package sad_pkg;

  typedef enum logic [2:0] {
    StIdle           = 3'd0,
    StInput          = 3'd1,
    StProcess        = 3'd2,
    StAdvance        = 3'd3,
    StFinishMatch    = 3'd4,
    StFinishNotmatch = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SendOff      = 2'd0,
    SendMatch    = 2'd1,
    SendNotMatch = 2'd2
  } uart_send_e;

endpackage

// File: rtl/sad_window_counter.sv
// Template window walker: tcol/trow element counters, the linear template ROM
// address, the end-of-row shift condition and the last-element flag.
// rom_addr is kept as its own running counter so no trow*TPL_W multiply is needed.
module sad_window_counter #(
  parameter int unsigned TPL_W = 40,
  parameter int unsigned TPL_H = 100,
  parameter int unsigned RW    = 9,
  parameter int unsigned AW    = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [AW-1:0] rom_addr,
  output logic [RW-1:0] trow,
  output logic          col_last,
  output logic          last
);

  localparam int unsigned CW = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam logic [CW-1:0] ColMax = CW'(TPL_W - 1);
  localparam logic [RW-1:0] RowMax = RW'(TPL_H - 1);
  localparam logic [CW-1:0] ColOne = CW'(1);
  localparam logic [RW-1:0] RowOne = RW'(1);
  localparam logic [AW-1:0] AddrOne = AW'(1);

  logic [CW-1:0] tcol_q, tcol_d;
  logic [RW-1:0] trow_q, trow_d;
  logic [AW-1:0] addr_q, addr_d;

  assign col_last = (tcol_q == ColMax);
  assign last     = col_last && (trow_q == RowMax);
  assign rom_addr = addr_q;
  assign trow     = trow_q;

  // Next element: clear wins; enable steps one element, wrapping tcol into trow.
  always_comb begin
    tcol_d = tcol_q;
    trow_d = trow_q;
    addr_d = addr_q;
    if (clear) begin
      tcol_d = '0;
      trow_d = '0;
      addr_d = '0;
    end else if (enable) begin
      addr_d = addr_q + AddrOne;
      if (col_last) begin
        tcol_d = '0;
        trow_d = trow_q + RowOne;
      end else begin
        tcol_d = tcol_q + ColOne;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcol_q <= '0;
      trow_q <= '0;
      addr_q <= '0;
    end else begin
      tcol_q <= tcol_d;
      trow_q <= trow_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/sad_match_sequencer.sv
// SAD template-matching control sequencer. Scans every vertical template
// position of a buffered column band, drives ROM/RAM addresses and PE strobes,
// and reports match / no-match (plus the matching row) to the UART sender.
// Optional feature: define SAD_SCAN_ALL_EN to add scan_all / match_count,
// which scans every position and counts matches instead of stopping at the first.
module sad_match_sequencer
  import sad_pkg::*;
#(
  parameter int unsigned TPL_W = 40,
  parameter int unsigned TPL_H = 100,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned RW    = $clog2(IMG_H),
  parameter int unsigned AW    = $clog2(TPL_W * TPL_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          uart_start,
  input  logic          fifo_ready,
  input  logic          pe_match,
  input  logic          uart_send_complete,
  output logic [RW-1:0] current_row,
  output logic [RW-1:0] ram_addr,
  output logic [AW-1:0] rom_addr,
  output logic          pe_shift,
  output logic          pe_reset,
  output logic [1:0]    uart_send,
  output logic [RW-1:0] match_row,
  output logic [2:0]    state
`ifdef SAD_SCAN_ALL_EN
  ,
  input  logic          scan_all,
  output logic [RW:0]   match_count
`endif
);

  localparam logic [RW-1:0] LastRow = RW'(IMG_H - TPL_H);
  localparam logic [RW-1:0] RowOne  = RW'(1);

  state_e       state_q, state_d;
  uart_send_e   send_q, send_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] match_row_q, match_row_d;
  logic          cnt_clear, cnt_en;
  logic [RW-1:0] trow;
  logic          col_last, win_last;

`ifdef SAD_SCAN_ALL_EN
  localparam logic [RW:0] CountOne = (RW+1)'(1);
  logic          scan_q, scan_d;
  logic [RW:0]   count_q, count_d;
`endif

  sad_window_counter #(
    .TPL_W (TPL_W),
    .TPL_H (TPL_H),
    .RW    (RW),
    .AW    (AW)
  ) u_window (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .rom_addr (rom_addr),
    .trow     (trow),
    .col_last (col_last),
    .last     (win_last)
  );

  // Next-state, row tracking and result decision.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    match_row_d = match_row_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    send_d      = SendOff;
`ifdef SAD_SCAN_ALL_EN
    scan_d      = scan_q;
    count_d     = count_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (uart_start) begin
          state_d     = StInput;
          cnt_clear   = 1'b1;
          row_d       = '0;
          match_row_d = '0;
`ifdef SAD_SCAN_ALL_EN
          scan_d      = scan_all;
          count_d     = '0;
`endif
        end
      end
      StInput: begin
        if (fifo_ready) state_d = StProcess;
      end
      StProcess: begin
        // A reject on the last element still counts as a reject.
        if (!pe_match) begin
          state_d   = StAdvance;
          cnt_clear = 1'b1;
        end else if (win_last) begin
`ifdef SAD_SCAN_ALL_EN
          if (scan_q) begin
            if (count_q == '0) match_row_d = row_q;
            count_d   = count_q + CountOne;
            state_d   = StAdvance;
            cnt_clear = 1'b1;
          end else begin
            match_row_d = row_q;
            state_d     = StFinishMatch;
          end
`else
          match_row_d = row_q;
          state_d     = StFinishMatch;
`endif
        end else begin
          cnt_en = 1'b1;
        end
      end
      StAdvance: begin
        cnt_clear = 1'b1;
        if (row_q == LastRow) begin
          state_d = StFinishNotmatch;
`ifdef SAD_SCAN_ALL_EN
          if (count_q != '0) state_d = StFinishMatch;
`endif
        end else begin
          row_d   = row_q + RowOne;
          state_d = StProcess;
        end
      end
      StFinishMatch, StFinishNotmatch: begin
        if (uart_send_complete) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Result code is a one-cycle pulse on entry to a finish state.
    if (state_d == StFinishMatch && state_q != StFinishMatch) begin
      send_d = SendMatch;
    end else if (state_d == StFinishNotmatch && state_q != StFinishNotmatch) begin
      send_d = SendNotMatch;
    end
  end

  // State, row and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      send_q      <= SendOff;
      row_q       <= '0;
      match_row_q <= '0;
    end else begin
      state_q     <= state_d;
      send_q      <= send_d;
      row_q       <= row_d;
      match_row_q <= match_row_d;
    end
  end

`ifdef SAD_SCAN_ALL_EN
  // Scan-all mode latch and match counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_q  <= 1'b0;
      count_q <= '0;
    end else begin
      scan_q  <= scan_d;
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

  assign current_row = row_q;
  assign ram_addr    = row_q + trow;
  assign pe_shift    = (state_q == StProcess) && col_last;
  assign pe_reset    = reset || (state_q == StIdle) || (state_q == StInput) ||
                       (state_q == StAdvance);
  assign uart_send   = send_q;
  assign match_row   = match_row_q;
  assign state       = state_q;

endmodule

// File: tb/tb_sad_match_sequencer.sv
// Bench for sad_match_sequencer at default sizes (40x100 template, 480 rows).
// Table of scan scenarios plus hand sequences for reject-at-row-end and
// mid-scan reset; expected results go through a scoreboard queue.
module tb_sad_match_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_start;
  logic        fifo_ready;
  logic        pe_match;
  logic        uart_send_complete;
  logic [8:0]  current_row;
  logic [8:0]  ram_addr;
  logic [11:0] rom_addr;
  logic        pe_shift;
  logic        pe_reset;
  logic [1:0]  uart_send;
  logic [8:0]  match_row;
  logic [2:0]  state;
`ifdef SAD_SCAN_ALL_EN
  logic        scan_all;
  logic [9:0]  match_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // pe_match pattern selector: 0 all-1, 1 only tgt_row, 2 all-0,
  // 3 all-1 except (tgt_row, tgt_el), 4 only rows 10 and 300.
  int mode    = 0;
  int tgt_row = 0;
  int tgt_el  = 0;

  typedef struct {
    int mode; int row; int el; int hold;
    int exp_send; int exp_row; int exp_proc; int exp_adv; int exp_count;
  } vec_t;

  typedef struct { int send; int row; } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  sad_match_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .uart_start         (uart_start),
    .fifo_ready         (fifo_ready),
    .pe_match           (pe_match),
    .uart_send_complete (uart_send_complete),
    .current_row        (current_row),
    .ram_addr           (ram_addr),
    .rom_addr           (rom_addr),
    .pe_shift           (pe_shift),
    .pe_reset           (pe_reset),
    .uart_send          (uart_send),
    .match_row          (match_row),
    .state              (state)
`ifdef SAD_SCAN_ALL_EN
    ,
    .scan_all           (scan_all),
    .match_count        (match_count)
`endif
  );

  always #5 clock = ~clock;

  always_comb begin
    case (mode)
      0: pe_match = 1'b1;
      1: pe_match = (int'(current_row) == tgt_row);
      2: pe_match = 1'b0;
      3: pe_match = !(int'(current_row) == tgt_row && int'(rom_addr) == tgt_el);
      4: pe_match = (int'(current_row) == 10) || (int'(current_row) == 300);
      default: pe_match = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_scan();
    uart_start = 1'b1;
    step();
    uart_start = 1'b0;
    check("input_state", int'(state), 1);
    check("input_pe_reset", int'(pe_reset), 1);
    fifo_ready = 1'b1;
    step();
    fifo_ready = 1'b0;
    check("first_state", int'(state), 2);
    check("first_rom", int'(rom_addr), 0);
    check("first_ram", int'(ram_addr), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int proc = 0, adv = 0, viol = 0, maxram = 0;
    bit seen = 1'b0;
    sb_t e;
    mode    = v.mode;
    tgt_row = v.row;
    tgt_el  = v.el;
`ifdef SAD_SCAN_ALL_EN
    scan_all = (v.mode == 4);
`endif
    e.send = v.exp_send;
    e.row  = v.exp_row;
    sbq.push_back(e);
    start_scan();
`ifdef SAD_SCAN_ALL_EN
    scan_all = 1'b0;
`endif
    for (int c = 0; c < 20000; c++) begin
      if (uart_send != 2'd0) begin
        seen = 1'b1;
        break;
      end
      if (state == 3'd2) begin
        proc++;
        if (pe_shift != ((rom_addr % 40) == 39)) viol++;
        if (int'(ram_addr) != int'(current_row) + int'(rom_addr) / 40) viol++;
      end else if (state == 3'd3) begin
        adv++;
        if (pe_shift || !pe_reset) viol++;
      end
      if (int'(ram_addr) > maxram) maxram = int'(ram_addr);
      step();
    end
    check("send_seen", int'(seen), 1);
    if (seen && sbq.size() > 0) begin
      e = sbq.pop_front();
      check("uart_send", int'(uart_send), e.send);
      check("match_row", int'(match_row), e.row);
      check("finish_state", int'(state), (e.send == 1) ? 4 : 5);
    end
    check("process_cycles", proc, v.exp_proc);
    check("advance_cycles", adv, v.exp_adv);
    check("per_cycle_violations", viol, 0);
    check("ram_addr_in_range", int'(maxram <= 479), 1);
`ifdef SAD_SCAN_ALL_EN
    check("match_count", int'(match_count), v.exp_count);
`endif
    for (int h = 0; h < v.hold; h++) begin
      step();
      check("send_pulse_end", int'(uart_send), 0);
      check("finish_hold", int'(state), (v.exp_send == 1) ? 4 : 5);
      check("match_row_hold", int'(match_row), v.exp_row);
    end
    uart_send_complete = 1'b1;
    step();
    uart_send_complete = 1'b0;
    check("back_idle", int'(state), 0);
    check("idle_send_off", int'(uart_send), 0);
  endtask

  initial begin
    vec_t v;
    bit   hit;
    int   shifts;

    // mode row el hold | send row proc adv count
    v = '{0, 0, 0, 2, 1, 0, 4000, 0, 0};       vecs.push_back(v);
    v = '{1, 57, 0, 0, 1, 57, 4057, 57, 0};    vecs.push_back(v);
    v = '{1, 380, 0, 0, 1, 380, 4380, 380, 0}; vecs.push_back(v);
    v = '{2, 0, 0, 1, 2, 0, 381, 381, 0};      vecs.push_back(v);
    v = '{3, 0, 39, 0, 1, 1, 4040, 1, 0};      vecs.push_back(v);
    v = '{3, 0, 3999, 0, 1, 1, 8000, 1, 0};    vecs.push_back(v);
`ifdef SAD_SCAN_ALL_EN
    v = '{4, 0, 0, 0, 1, 10, 8379, 381, 2};    vecs.push_back(v);
    scan_all = 1'b0;
`endif

    reset              = 1'b1;
    uart_start         = 1'b0;
    fifo_ready         = 1'b0;
    uart_send_complete = 1'b0;
    step();
    step();
    check("rst_state", int'(state), 0);
    check("rst_pe_reset", int'(pe_reset), 1);
    check("rst_current_row", int'(current_row), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_pe_shift", int'(pe_shift), 0);
    check("rst_uart_send", int'(uart_send), 0);
    check("rst_match_row", int'(match_row), 0);
    reset = 1'b0;
    step();
    check("idle_state", int'(state), 0);
    check("idle_pe_reset", int'(pe_reset), 1);

    // Reject on the final column of template row 0.
    mode = 3; tgt_row = 0; tgt_el = 39;
    start_scan();
    shifts = 0;
    for (int i = 0; i < 40; i++) begin
      if (pe_shift) shifts++;
      step();
    end
    check("rej_pe_shift_once", shifts, 1);
    check("rej_advance", int'(state), 3);
    check("rej_rom_cleared", int'(rom_addr), 0);
    check("rej_adv_pe_reset", int'(pe_reset), 1);
    step();
    check("rej_next_process", int'(state), 2);
    check("rej_next_row", int'(current_row), 1);
    check("rej_next_ram", int'(ram_addr), 1);
    check("rej_next_rom", int'(rom_addr), 0);

    // Reset pulsed mid-PROCESS at row 200.
    reset = 1'b1;
    step();
    reset = 1'b0;
    mode = 2;
    start_scan();
    hit = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (state == 3'd2 && current_row == 9'd200) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("reach_row200", int'(hit), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_row", int'(current_row), 0);
    check("mid_rst_ram", int'(ram_addr), 0);
    check("mid_rst_rom", int'(rom_addr), 0);
    check("mid_rst_send", int'(uart_send), 0);
    check("mid_rst_pe_reset", int'(pe_reset), 1);
    step();
    check("post_rst_state", int'(state), 0);
    check("post_rst_send", int'(uart_send), 0);
    check("post_rst_pe_reset", int'(pe_reset), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    check("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_match_sequencer.md
# sad_match_sequencer

Parametrised control sequencer for the SAD template-matching processor. It scans every vertical template position of a buffered image column band and drives the template ROM address, image RAM row address, and PE shift/reset strobes. It decides match or no-match and hands the result to the UART sender. It sits between the UART/FIFO front end and the PE array, and generalises the fixed 40×100 / 480-row controller to arbitrary template and image sizes. It adds a reported match row and an optional scan-all mode.

## Interface
Parameters:
- TPL_W, 40, template width in pixels (one PE row per template row)
- TPL_H, 100, template height in rows
- IMG_H, 480, image height in rows; requires IMG_H ≥ TPL_H
- RW, $clog2(IMG_H), row-index width (derived)
- AW, $clog2(TPL_W*TPL_H), ROM address width (derived)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- uart_start  in  1  start request; sampled only in IDLE
- fifo_ready  in  1  image band loaded; sampled only in INPUT
- pe_match  in  1  PE accumulated SAD still within threshold; sampled every PROCESS cycle
- uart_send_complete  in  1  UART result transmission done
- current_row  out  RW  image row of the template's top edge
- ram_addr  out  RW  image RAM row = current_row + template row counter
- rom_addr  out  AW  template ROM address = trow*TPL_W + tcol
- pe_shift  out  1  PE row shift strobe
- pe_reset  out  1  PE accumulator clear
- uart_send  out  2  0 OFF, 1 MATCH, 2 NOT_MATCH
- match_row  out  RW  current_row of the reported match
- state  out  3  FSM state, for debug
- scan_all  in  1  only with SCAN_ALL_EN
- match_count  out  RW+1  only with SCAN_ALL_EN

## Operation
- States:
  - IDLE=0: uart_start → INPUT.
  - INPUT=1: fifo_ready → PROCESS.
  - PROCESS=2: window in progress.
  - ADVANCE=3: one cycle.
  - FINISH_MATCH=4 and FINISH_NOTMATCH=5: uart_send_complete → IDLE.
- PROCESS:
  - Counters tcol 0..TPL_W-1 and trow 0..TPL_H-1 advance one element per cycle; tcol wraps to 0 and trow increments when tcol==TPL_W-1.
  - pe_shift=1 exactly when tcol==TPL_W-1.
- Reject: pe_match=0 in any PROCESS cycle → ADVANCE. Rejection takes priority over the last-element check.
- Accept: pe_match=1 on the last element (tcol==TPL_W-1, trow==TPL_H-1):
  - match_row←current_row.
  - First-match mode: → FINISH_MATCH.
- ADVANCE:
  - Counters clear.
  - If current_row==IMG_H-TPL_H → FINISH_NOTMATCH.
  - Otherwise current_row+1 → PROCESS.
- pe_reset=1 when reset, or when state is IDLE, INPUT or ADVANCE.
- uart_send is 1 or 2 for exactly the first cycle in FINISH_MATCH or FINISH_NOTMATCH, and 0 otherwise.
- current_row, counters and match_row clear on IDLE→INPUT. Outputs hold their values in FINISH states.
- Reset values: state=IDLE, all counters and outputs 0, pe_reset=1.
- Reset mid-scan: back to IDLE on the next edge; nothing is sent.
- Arithmetic is unsigned. current_row never exceeds IMG_H-TPL_H, so ram_addr ≤ IMG_H-1 with no wrap.

## Timing
- fifo_ready sampled high → the next cycle is PROCESS with rom_addr=0, ram_addr=current_row.
- rom_addr and ram_addr are combinational from registered counters and are valid in the same cycle.
- Full window: TPL_W*TPL_H PROCESS cycles plus 1 ADVANCE. A window rejected at element k costs k+1 cycles plus 1.
- Decision-to-uart_send latency: one edge after the final PROCESS or ADVANCE cycle.
- uart_send_complete is ignored until the state is FINISH; it may be asserted in the first FINISH cycle.

## Configuration
- SAD_SCAN_ALL_EN defined: scan_all and match_count exist. With scan_all=1, an accept increments match_count, records match_row only for the first match, and goes to ADVANCE. After the last position, the FSM goes to FINISH_MATCH if match_count>0, else FINISH_NOTMATCH. scan_all is sampled in IDLE only.
- Undefined: ports absent; first-match mode only.

## Structure
- Package sad_pkg:
  - state encodings IDLE…FINISH_NOTMATCH as a 3-bit enum.
  - uart_send codes OFF/MATCH/NOT_MATCH.
- Sub-module sad_window_counter: tcol/trow counters, rom_addr, pe_shift, last-element flag. Inputs are clear and enable.
- FSM, row tracking and result logic stay in the top module.

## Test plan
All scenarios use the defaults (TPL_W=40, TPL_H=100, IMG_H=480, last row 380).
- pe_match always 1 → FINISH_MATCH after 4000 PROCESS cycles; match_row=0; uart_send=1 for one cycle.
- pe_match is 0 except while current_row==57 → match_row=57; uart_send=1.
- pe_match always 0 → 381 positions of 2 cycles each; FINISH_NOTMATCH; uart_send=2; ram_addr never exceeds 479.
- pe_match drops at element 39 of row 0 → pe_shift seen once; ADVANCE; current_row=1; rom_addr returns to 0.
- reset pulsed mid-PROCESS at current_row=200 → next cycle IDLE, all outputs 0, pe_reset=1; a new start rescans from row 0.
- SAD_SCAN_ALL_EN, scan_all=1, matches at rows 10 and 300 → FINISH_MATCH after row 380; match_count=2; match_row=10.
